// File: rtl/mmu_pkg.sv
// Shared definitions for the page-map controller: FSM encoding and the
// power-on page-map contents.
package mmu_pkg;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_CPU_WR  = 3'd2,
    S_SAVE    = 3'd3,
    S_RESTORE = 3'd4
  } state_t;

  localparam int unsigned INIT_ENTRY0      = 0;
  localparam int unsigned INIT_ENTRY_OTHER = 1;

  function automatic int unsigned init_entry(int unsigned idx);
    return (idx == 0) ? INIT_ENTRY0 : INIT_ENTRY_OTHER;
  endfunction

endpackage

// File: rtl/mmu_map_store.sv
// Shadow copy of the external page map plus a context store that can
// snapshot the whole shadow in one cycle.
module mmu_map_store
  import mmu_pkg::*;
#(
  parameter int DW = 3,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_adr,
  input  logic [DW-1:0] wr_data,
  input  logic          snap,
  input  logic [AW-1:0] rd_adr,
  output logic [DW-1:0] ctx_data
);

  localparam int NE = 1 << AW;

  logic [DW-1:0] shadow [0:NE-1];
  logic [DW-1:0] ctx    [0:NE-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NE; i++) begin
        shadow[i] <= DW'(init_entry(i));
        ctx[i]    <= DW'(init_entry(i));
      end
    end else begin
      if (we) shadow[wr_adr] <= wr_data;
      if (snap) begin
        for (int i = 0; i < NE; i++) ctx[i] <= shadow[i];
      end
    end
  end

  assign ctx_data = ctx[rd_adr];

endmodule

// File: rtl/mmu_map_ctrl.sv
// Page-map sequencer: default fill, locked CPU writes, context save/restore.
//   state     | meaning
//   S_INIT    | write default map, one entry per cycle
//   S_IDLE    | arbitrate ctx_req over cpu_req
//   S_CPU_WR  | single CPU write (rejected when write-locked)
//   S_SAVE    | snapshot shadow into context store
//   S_RESTORE | replay context store into map, one entry per cycle
module mmu_map_ctrl
  import mmu_pkg::*;
#(
  parameter int DW = 3,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_data,
  output logic          cpu_ack,
  output logic          cpu_err,
  input  logic          unlock,
  input  logic          lock,
  input  logic          ctx_req,
  input  logic          ctx_op,
  output logic          ctx_ack,
  output logic          map_we,
  output logic [AW-1:0] map_adr,
  output logic [DW-1:0] map_data,
  output logic          busy,
  output logic          wr_en
);

  localparam logic [AW-1:0] LAST = '1;

  state_t        state;
  logic [AW-1:0] idx;
  logic          w_en;
  logic [AW-1:0] w_adr;
  logic [DW-1:0] w_data;
  logic          snap;
  logic [DW-1:0] ctx_rd;

  mmu_map_store #(.DW(DW), .AW(AW)) u_store (
    .clk      (clk),
    .reset    (reset),
    .we       (w_en),
    .wr_adr   (w_adr),
    .wr_data  (w_data),
    .snap     (snap),
    .rd_adr   (idx),
    .ctx_data (ctx_rd)
  );

  // Write intent for this cycle; feeds the shadow and the registered map port alike.
  always_comb begin
    w_en   = 1'b0;
    w_adr  = '0;
    w_data = '0;
    snap   = 1'b0;
    case (state)
      S_INIT: begin
        w_en   = 1'b1;
        w_adr  = idx;
        w_data = DW'(init_entry(32'(idx)));
      end
      S_CPU_WR: begin
        w_en   = wr_en;
        w_adr  = cpu_adr;
        w_data = cpu_data;
      end
      S_SAVE:    snap = 1'b1;
      S_RESTORE: begin
        w_en   = 1'b1;
        w_adr  = idx;
        w_data = ctx_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_INIT;
      idx      <= '0;
      wr_en    <= 1'b0;
      busy     <= 1'b1;
      map_we   <= 1'b0;
      map_adr  <= '0;
      map_data <= '0;
      cpu_ack  <= 1'b0;
      cpu_err  <= 1'b0;
      ctx_ack  <= 1'b0;
    end else begin
      if (lock)        wr_en <= 1'b0;
      else if (unlock) wr_en <= 1'b1;

      busy     <= (state != S_IDLE);
      map_we   <= w_en;
      map_adr  <= w_en ? w_adr : '0;
      map_data <= w_en ? w_data : '0;
      cpu_ack  <= 1'b0;
      cpu_err  <= 1'b0;
      ctx_ack  <= 1'b0;

      case (state)
        S_INIT: begin
          idx <= idx + 1'b1;
          if (idx == LAST) state <= S_IDLE;
        end
        S_IDLE: begin
          idx <= '0;
          if (ctx_req)      state <= ctx_op ? S_RESTORE : S_SAVE;
          else if (cpu_req) state <= S_CPU_WR;
        end
        S_CPU_WR: begin
          cpu_ack <= 1'b1;
          cpu_err <= ~wr_en;
          state   <= S_IDLE;
        end
        S_SAVE: begin
          ctx_ack <= 1'b1;
          state   <= S_IDLE;
        end
        S_RESTORE: begin
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            ctx_ack <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          state <= S_INIT;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_map_ctrl.sv
// Bench for mmu_map_ctrl: directed scenarios plus random operations checked
// against an array model of the map, context store and write-enable.
module tb_mmu_map_ctrl;

  localparam int DW = 3;
  localparam int AW = 3;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_adr = '0;
  logic [DW-1:0] cpu_data = '0;
  logic          unlock = 1'b0;
  logic          lock = 1'b0;
  logic          ctx_req = 1'b0;
  logic          ctx_op = 1'b0;
  logic          cpu_ack, cpu_err, ctx_ack, map_we, busy, wr_en;
  logic [AW-1:0] map_adr;
  logic [DW-1:0] map_data;

  int checks = 0;
  int errors = 0;
  int map_ref [N];
  int ctx_ref [N];
  int ext_map [N];
  bit wr_en_ref;
  int log_adr [$];
  int log_data [$];
  int cpu_acks = 0;
  int ctx_acks = 0;
  int cyc = 0;

  mmu_map_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_adr(cpu_adr), .cpu_data(cpu_data),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .unlock(unlock), .lock(lock),
    .ctx_req(ctx_req), .ctx_op(ctx_op), .ctx_ack(ctx_ack),
    .map_we(map_we), .map_adr(map_adr), .map_data(map_data),
    .busy(busy), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic int init_val(int i);
    return (i == 0) ? 0 : 1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then observe at the falling edge and log bus activity.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (map_we === 1'b1) begin
      log_adr.push_back(int'(map_adr));
      log_data.push_back(int'(map_data));
      ext_map[map_adr] = int'(map_data);
    end else begin
      check("bus_quiet", {map_adr, map_data}, 0);
    end
    if (cpu_ack === 1'b1) cpu_acks++;
    else check("err_without_ack", cpu_err, 0);
    if (ctx_ack === 1'b1) ctx_acks++;
  endtask

  task automatic check_map(string tag);
    logic [31:0] pk, pk_ref;
    pk = 0;
    pk_ref = 0;
    for (int i = 0; i < N; i++) begin
      pk     |= 32'(ext_map[i]) << (4 * i);
      pk_ref |= 32'(map_ref[i]) << (4 * i);
    end
    check(tag, pk, pk_ref);
  endtask

  task automatic check_init();
    for (int k = 0; k < N; k++) begin
      tick();
      check("init_we", map_we, 1);
      check("init_adr", map_adr, k);
      check("init_data", map_data, init_val(k));
      check("init_busy", busy, 1);
    end
    tick();
    check("init_busy_fall", busy, 0);
    for (int i = 0; i < N; i++) map_ref[i] = init_val(i);
    check_map("init_map");
  endtask

  task automatic do_reset(int hold);
    reset = 1'b1;
    repeat (hold) tick();
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 1);
    check("rst_map_we", map_we, 0);
    check("rst_acks", {cpu_ack, cpu_err, ctx_ack}, 0);
    reset = 1'b0;
    wr_en_ref = 1'b0;
    for (int i = 0; i < N; i++) ctx_ref[i] = init_val(i);
    check_init();
  endtask

  task automatic pulse(bit u, bit l);
    unlock = u;
    lock = l;
    tick();
    unlock = 1'b0;
    lock = 1'b0;
    if (l) wr_en_ref = 1'b0;
    else if (u) wr_en_ref = 1'b1;
    check("wr_en", wr_en, wr_en_ref);
  endtask

  task automatic cpu_write(int a, int d);
    int n0, a0, nw;
    bit got;
    n0 = log_adr.size();
    a0 = cpu_acks;
    got = 0;
    cpu_adr = AW'(a);
    cpu_data = DW'(d);
    cpu_req = 1'b1;
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      if (cpu_ack === 1'b1) got = 1;
    end
    cpu_req = 1'b0;
    check("cpu_ack_seen", got, 1);
    if (got) check("cpu_err", cpu_err, !wr_en_ref);
    nw = log_adr.size() - n0;
    check("cpu_we_count", nw, wr_en_ref ? 1 : 0);
    if (wr_en_ref && nw == 1) begin
      check("cpu_we_adr", log_adr[n0], a);
      check("cpu_we_data", log_data[n0], d);
    end
    if (wr_en_ref) map_ref[a] = d;
    repeat (2) tick();
    check("cpu_ack_once", cpu_acks - a0, 1);
    check_map("map_after_cpu");
  endtask

  task automatic ctx_cmd(bit op);
    int n0, a0, nw;
    bit got;
    n0 = log_adr.size();
    a0 = ctx_acks;
    got = 0;
    ctx_op = op;
    ctx_req = 1'b1;
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      if (ctx_ack === 1'b1) got = 1;
    end
    ctx_req = 1'b0;
    check("ctx_ack_seen", got, 1);
    nw = log_adr.size() - n0;
    if (op) begin
      if (got) check("ctx_ack_on_last", {map_we, map_adr}, {1'b1, AW'(N - 1)});
      check("restore_count", nw, N);
      for (int k = 0; k < N && k < nw; k++) begin
        check("restore_adr", log_adr[n0 + k], k);
        check("restore_data", log_data[n0 + k], ctx_ref[k]);
      end
      for (int i = 0; i < N; i++) map_ref[i] = ctx_ref[i];
    end else begin
      check("save_no_we", nw, 0);
      for (int i = 0; i < N; i++) ctx_ref[i] = map_ref[i];
    end
    repeat (2) tick();
    check("ctx_ack_once", ctx_acks - a0, 1);
    check_map("map_after_ctx");
  endtask

  // Both requesters raise together; the context operation must win.
  task automatic both_req(bit op, int a, int d);
    int n0, c0, x0, ctx_cyc, cpu_cyc, nw;
    n0 = log_adr.size();
    c0 = cpu_acks;
    x0 = ctx_acks;
    ctx_cyc = -1;
    cpu_cyc = -1;
    ctx_op = op;
    cpu_adr = AW'(a);
    cpu_data = DW'(d);
    ctx_req = 1'b1;
    cpu_req = 1'b1;
    for (int t = 0; t < 60 && (ctx_cyc < 0 || cpu_cyc < 0); t++) begin
      tick();
      if (ctx_ack === 1'b1 && ctx_cyc < 0) begin ctx_cyc = cyc; ctx_req = 1'b0; end
      if (cpu_ack === 1'b1 && cpu_cyc < 0) begin
        cpu_cyc = cyc;
        cpu_req = 1'b0;
        check("both_cpu_err", cpu_err, !wr_en_ref);
      end
    end
    ctx_req = 1'b0;
    cpu_req = 1'b0;
    check("both_ctx_first", (ctx_cyc >= 0 && cpu_cyc > ctx_cyc), 1);
    nw = log_adr.size() - n0;
    check("both_we_count", nw, (op ? N : 0) + (wr_en_ref ? 1 : 0));
    if (op) for (int i = 0; i < N; i++) map_ref[i] = ctx_ref[i];
    else    for (int i = 0; i < N; i++) ctx_ref[i] = map_ref[i];
    if (wr_en_ref) map_ref[a] = d;
    repeat (2) tick();
    check("both_cpu_once", cpu_acks - c0, 1);
    check("both_ctx_once", ctx_acks - x0, 1);
    check_map("map_after_both");
  endtask

  initial begin
    int hit, x0;
    for (int i = 0; i < N; i++) ext_map[i] = 0;

    do_reset(3);

    // rejected write while locked, then accepted after unlock
    cpu_write(3, 5);
    pulse(1'b1, 1'b0);
    cpu_write(3, 5);

    // save / overwrite / restore brings the saved value back
    cpu_write(2, 6);
    ctx_cmd(1'b0);
    cpu_write(2, 4);
    ctx_cmd(1'b1);
    check("restored_adr2", ext_map[2], 6);

    both_req(1'b1, 5, 2);
    both_req(1'b0, 6, 7);

    // simultaneous lock+unlock clears
    pulse(1'b1, 1'b1);
    check("lock_wins", wr_en, 0);
    cpu_write(1, 3);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0, 1: cpu_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, (1 << DW) - 1)));
        2: ctx_cmd(1'b0);
        3: ctx_cmd(1'b1);
        4: pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: both_req(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                          int'($urandom_range(0, (1 << DW) - 1)));
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end

    // reset in the middle of a restore
    pulse(1'b1, 1'b0);
    x0 = ctx_acks;
    hit = 0;
    ctx_op = 1'b1;
    ctx_req = 1'b1;
    for (int t = 0; t < 40 && hit == 0; t++) begin
      tick();
      if (map_we === 1'b1 && map_adr === AW'(4)) hit = 1;
    end
    check("restore_reached_idx4", hit, 1);
    reset = 1'b1;
    ctx_req = 1'b0;
    tick();
    check("abort_ctx_ack", ctx_ack, 0);
    check("abort_map_we", map_we, 0);
    check("abort_busy", busy, 1);
    check("abort_wr_en", wr_en, 0);
    reset = 1'b0;
    wr_en_ref = 1'b0;
    for (int i = 0; i < N; i++) ctx_ref[i] = init_val(i);
    check_init();
    check("abort_no_ack", ctx_acks - x0, 0);
    check("post_abort_wr_en", wr_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
